// File: rtl/music_key_debouncer.sv
// Six-channel music-key conditioner: sync, debounce, edge pulses and a
// valid/ready key-event stream with per-key pending storage.
module music_key_debouncer #(
    parameter int NUM_KEYS    = 6,
    parameter int DEBOUNCE_MS = 20,
    parameter int CNT_W       = 6
) (
    input  logic                CLK_1Khz,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] raw_MusicKey,
    output logic [NUM_KEYS-1:0] debounced_MusicKey,
    output logic [NUM_KEYS-1:0] keyPressed_pulse,
    output logic [NUM_KEYS-1:0] keyReleased_pulse,
    output logic                keyEvent_valid,
    output logic [2:0]          keyEvent_key,
    output logic                keyEvent_press,
    input  logic                keyEvent_ready,
    output logic                keyEvent_overflow
);

    typedef enum logic [1:0] {
        UP,
        ARM_DOWN,
        DOWN,
        ARM_UP
    } key_state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);

    logic [NUM_KEYS-1:0] sync1_q, sync1_d;
    logic [NUM_KEYS-1:0] sync2_q, sync2_d;
    logic [NUM_KEYS-1:0] stable_q, stable_d;
    logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_d [NUM_KEYS];
    key_state_e          state_q [NUM_KEYS];
    key_state_e          state_d [NUM_KEYS];
    logic [NUM_KEYS-1:0] press_pulse_q, press_pulse_d;
    logic [NUM_KEYS-1:0] release_pulse_q, release_pulse_d;
    logic [NUM_KEYS-1:0] pend_press_q, pend_press_d;
    logic [NUM_KEYS-1:0] pend_release_q, pend_release_d;
    logic                overflow_q, overflow_d;

    logic [NUM_KEYS-1:0] mismatch;
    logic [NUM_KEYS-1:0] done;
    logic [NUM_KEYS-1:0] toggle;
    logic [NUM_KEYS-1:0] clr_press;
    logic [NUM_KEYS-1:0] clr_release;
    logic                ev_valid;
    logic                ev_found;
    logic [2:0]          sel_idx;
    logic                sel_press;
    logic                accept;

    // Datapath registers
    always_ff @(posedge CLK_1Khz) begin
        if (!reset_n) begin
            sync1_q         <= '1;
            sync2_q         <= '1;
            stable_q        <= '1;
            press_pulse_q   <= '0;
            release_pulse_q <= '0;
            pend_press_q    <= '0;
            pend_release_q  <= '0;
            overflow_q      <= 1'b0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            stable_q        <= stable_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            pend_press_q    <= pend_press_d;
            pend_release_q  <= pend_release_d;
            overflow_q      <= overflow_d;
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // FSM state register
    always_ff @(posedge CLK_1Khz) begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (!reset_n) begin
                state_q[i] <= UP;
            end else begin
                state_q[i] <= state_d[i];
            end
        end
    end

    always_comb begin
        sync1_d = raw_MusicKey;
        sync2_d = sync1_q;
        for (int i = 0; i < NUM_KEYS; i++) begin
            mismatch[i] = sync2_q[i] != stable_q[i];
            done[i]     = mismatch[i] && (cnt_q[i] == CNT_LAST);
            cnt_d[i]    = '0;
            if (mismatch[i] && !done[i]) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // FSM next state
    always_comb begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            state_d[i] = state_q[i];
            unique case (state_q[i])
                UP: begin
                    if (mismatch[i]) state_d[i] = ARM_DOWN;
                end
                ARM_DOWN: begin
                    if (!mismatch[i])  state_d[i] = UP;
                    else if (done[i])  state_d[i] = DOWN;
                end
                DOWN: begin
                    if (mismatch[i]) state_d[i] = ARM_UP;
                end
                ARM_UP: begin
                    if (!mismatch[i])  state_d[i] = DOWN;
                    else if (done[i])  state_d[i] = UP;
                end
                default: state_d[i] = UP;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            toggle[i] = done[i] &&
                ((state_q[i] == ARM_DOWN) || (state_q[i] == ARM_UP));
            stable_d[i]        = stable_q[i] ^ toggle[i];
            press_pulse_d[i]   = toggle[i] && (state_q[i] == ARM_DOWN);
            release_pulse_d[i] = toggle[i] && (state_q[i] == ARM_UP);
        end
    end

    // Lowest pending key wins; with both pending, the older edge goes first
    always_comb begin
        ev_valid  = |(pend_press_q | pend_release_q);
        ev_found  = 1'b0;
        sel_idx   = '0;
        sel_press = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (!ev_found && (pend_press_q[i] || pend_release_q[i])) begin
                ev_found  = 1'b1;
                sel_idx   = 3'(i);
                sel_press = pend_press_q[i] &&
                    (!pend_release_q[i] || stable_q[i]);
            end
        end
    end

    always_comb begin
        accept     = ev_valid && keyEvent_ready;
        overflow_d = overflow_q;
        for (int i = 0; i < NUM_KEYS; i++) begin
            clr_press[i]   = accept && (sel_idx == 3'(i)) && sel_press;
            clr_release[i] = accept && (sel_idx == 3'(i)) && !sel_press;
            pend_press_d[i] = press_pulse_d[i] |
                (pend_press_q[i] & ~clr_press[i]);
            pend_release_d[i] = release_pulse_d[i] |
                (pend_release_q[i] & ~clr_release[i]);
            if (press_pulse_d[i] && pend_press_q[i] && !clr_press[i]) begin
                overflow_d = 1'b1;
            end
            if (release_pulse_d[i] && pend_release_q[i] &&
                !clr_release[i]) begin
                overflow_d = 1'b1;
            end
        end
    end

    assign debounced_MusicKey = stable_q;
    assign keyPressed_pulse   = press_pulse_q;
    assign keyReleased_pulse  = release_pulse_q;
    assign keyEvent_valid     = ev_valid;
    assign keyEvent_key       = sel_idx;
    assign keyEvent_press     = sel_press;
    assign keyEvent_overflow  = overflow_q;

endmodule

// File: tb/tb_music_key_debouncer.sv
// Bench for music_key_debouncer: directed table, hand sequence and
// random stimulus checked against a sample-window reference model.
module tb_music_key_debouncer;

    localparam int NK = 6;
    localparam int D  = 20;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NK-1:0] raw;
    logic [NK-1:0] deb;
    logic [NK-1:0] pressed;
    logic [NK-1:0] released;
    logic          ev_valid;
    logic [2:0]    ev_key;
    logic          ev_press;
    logic          ready;
    logic          ovf;

    int vectors     = 0;
    int miscompares = 0;

    music_key_debouncer #(
        .NUM_KEYS(NK),
        .DEBOUNCE_MS(D),
        .CNT_W(6)
    ) dut (
        .CLK_1Khz(clk),
        .reset_n(reset_n),
        .raw_MusicKey(raw),
        .debounced_MusicKey(deb),
        .keyPressed_pulse(pressed),
        .keyReleased_pulse(released),
        .keyEvent_valid(ev_valid),
        .keyEvent_key(ev_key),
        .keyEvent_press(ev_press),
        .keyEvent_ready(ready),
        .keyEvent_overflow(ovf)
    );

    always #5 clk = ~clk;

    // Reference model: a key's clean level flips once the last D samples
    // seen by the debouncer (raw delayed two edges) all disagree with it.
    bit hist [NK][$];
    bit m_stable [NK];
    bit m_pp [NK];
    bit m_pr [NK];
    bit m_pend_p [NK];
    bit m_pend_r [NK];
    bit m_ovf;

    function automatic void m_reset();
        for (int k = 0; k < NK; k++) begin
            hist[k].delete();
            for (int j = 0; j < D + 2; j++) hist[k].push_back(1'b1);
            m_stable[k] = 1'b1;
            m_pp[k]     = 1'b0;
            m_pr[k]     = 1'b0;
            m_pend_p[k] = 1'b0;
            m_pend_r[k] = 1'b0;
        end
        m_ovf = 1'b0;
    endfunction

    function automatic void m_present(output bit v, output bit [2:0] key,
                                      output bit press);
        v = 0;
        key = 0;
        press = 0;
        for (int k = NK - 1; k >= 0; k--) begin
            if (m_pend_p[k] || m_pend_r[k]) begin
                v = 1;
                key = 3'(k);
                press = m_pend_p[k] && (!m_pend_r[k] || m_stable[k]);
            end
        end
    endfunction

    function automatic void m_edge(bit [NK-1:0] r, bit rdy, bit rn);
        bit v, press, acc, tog, cp, cr;
        bit [2:0] key;
        if (!rn) begin
            m_reset();
            return;
        end
        m_present(v, key, press);
        acc = v && rdy;
        for (int k = 0; k < NK; k++) begin
            hist[k].push_back(r[k]);
            void'(hist[k].pop_front());
            tog = 1'b1;
            for (int j = 0; j < D; j++) begin
                if (hist[k][j] == m_stable[k]) tog = 1'b0;
            end
            m_pp[k] = tog && m_stable[k];
            m_pr[k] = tog && !m_stable[k];
            cp = acc && (key == 3'(k)) && press;
            cr = acc && (key == 3'(k)) && !press;
            if (m_pp[k] && m_pend_p[k] && !cp) m_ovf = 1'b1;
            if (m_pr[k] && m_pend_r[k] && !cr) m_ovf = 1'b1;
            m_pend_p[k] = m_pp[k] || (m_pend_p[k] && !cp);
            m_pend_r[k] = m_pr[k] || (m_pend_r[k] && !cr);
            if (tog) m_stable[k] = !m_stable[k];
        end
    endfunction

    task automatic check_model();
        bit v, press;
        bit [2:0] key;
        logic [NK-1:0] e_deb, e_pp, e_pr;
        logic [23:0] got, exp;
        m_present(v, key, press);
        for (int k = 0; k < NK; k++) begin
            e_deb[k] = m_stable[k];
            e_pp[k]  = m_pp[k];
            e_pr[k]  = m_pr[k];
        end
        exp = {e_deb, e_pp, e_pr, v, key, press, m_ovf};
        got = {deb, pressed, released, ev_valid, ev_key, ev_press, ovf};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL model t=%0t: got %h expected %h",
                     $time, got, exp);
        end
    endtask

    task automatic cycle(input logic [NK-1:0] r, input logic rdy,
                         input logic rn);
        raw = r;
        ready = rdy;
        reset_n = rn;
        m_edge(r, rdy, rn);
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    typedef struct {
        logic [NK-1:0] raw;
        logic          rdy;
        logic          rn;
        int            n;
        logic [NK-1:0] deb;
        logic          v;
        logic [2:0]    key;
        logic          press;
        logic          ovf;
    } vec_t;

    vec_t tbl [$];

    initial begin
        logic [11:0] got, exp;
        logic [NK-1:0] lvl;
        int hold [NK];
        int first_pulse, pulses;

        raw = '1;
        ready = 1'b1;
        reset_n = 1'b0;

        // raw, rdy, rn, n, deb, v, key, press, ovf
        tbl.push_back('{6'h3F, 1, 0,  2, 6'h3F, 0, 0, 0, 0});
        tbl.push_back('{6'h3E, 1, 1, 21, 6'h3F, 0, 0, 0, 0});
        tbl.push_back('{6'h3E, 1, 1,  1, 6'h3E, 1, 0, 1, 0});
        tbl.push_back('{6'h3E, 1, 1,  1, 6'h3E, 0, 0, 0, 0});
        tbl.push_back('{6'h3F, 1, 1, 22, 6'h3F, 1, 0, 0, 0});
        tbl.push_back('{6'h3F, 1, 1,  1, 6'h3F, 0, 0, 0, 0});
        tbl.push_back('{6'h1B, 1, 1, 22, 6'h1B, 1, 2, 1, 0});
        tbl.push_back('{6'h1B, 1, 1,  1, 6'h1B, 1, 5, 1, 0});
        tbl.push_back('{6'h1B, 1, 1,  1, 6'h1B, 0, 0, 0, 0});
        tbl.push_back('{6'h3F, 1, 1, 24, 6'h3F, 0, 0, 0, 0});
        tbl.push_back('{6'h2F, 0, 1, 30, 6'h2F, 1, 4, 1, 0});
        tbl.push_back('{6'h3F, 0, 1, 30, 6'h3F, 1, 4, 1, 0});
        tbl.push_back('{6'h3F, 1, 1,  1, 6'h3F, 1, 4, 0, 0});
        tbl.push_back('{6'h3F, 1, 1,  1, 6'h3F, 0, 0, 0, 0});
        tbl.push_back('{6'h3D, 0, 1, 25, 6'h3D, 1, 1, 1, 0});
        tbl.push_back('{6'h3F, 0, 1, 25, 6'h3F, 1, 1, 1, 0});
        tbl.push_back('{6'h3D, 0, 1, 25, 6'h3D, 1, 1, 0, 1});
        tbl.push_back('{6'h3D, 1, 1,  1, 6'h3D, 1, 1, 1, 1});
        tbl.push_back('{6'h3D, 1, 1,  1, 6'h3D, 0, 0, 0, 1});
        tbl.push_back('{6'h3F, 1, 1, 23, 6'h3F, 0, 0, 0, 1});
        tbl.push_back('{6'h3E, 1, 1, 10, 6'h3F, 0, 0, 0, 1});
        tbl.push_back('{6'h3E, 1, 0,  1, 6'h3F, 0, 0, 0, 0});
        tbl.push_back('{6'h3E, 1, 1, 21, 6'h3F, 0, 0, 0, 0});
        tbl.push_back('{6'h3E, 1, 1,  1, 6'h3E, 1, 0, 1, 0});
        tbl.push_back('{6'h3F, 1, 1, 23, 6'h3F, 0, 0, 0, 0});
        tbl.push_back('{6'h37, 1, 1,  3, 6'h3F, 0, 0, 0, 0});
        tbl.push_back('{6'h3F, 1, 1,  3, 6'h3F, 0, 0, 0, 0});
        tbl.push_back('{6'h37, 1, 1,  3, 6'h3F, 0, 0, 0, 0});
        tbl.push_back('{6'h3F, 1, 1,  3, 6'h3F, 0, 0, 0, 0});
        tbl.push_back('{6'h37, 1, 1, 21, 6'h3F, 0, 0, 0, 0});
        tbl.push_back('{6'h37, 1, 1,  1, 6'h37, 1, 3, 1, 0});
        tbl.push_back('{6'h37, 1, 1,  1, 6'h37, 0, 0, 0, 0});
        tbl.push_back('{6'h3F, 1, 1, 23, 6'h3F, 0, 0, 0, 0});

        for (int i = 0; i < tbl.size(); i++) begin
            for (int c = 0; c < tbl[i].n; c++) begin
                cycle(tbl[i].raw, tbl[i].rdy, tbl[i].rn);
            end
            exp = {tbl[i].deb, tbl[i].v, tbl[i].key,
                   tbl[i].press, tbl[i].ovf};
            got = {deb, ev_valid, ev_key, ev_press, ovf};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL table[%0d]: got %h expected %h",
                         i, got, exp);
            end
        end

        // Clean press of key 0: one pulse, visible after edge 22
        first_pulse = 0;
        pulses = 0;
        for (int c = 1; c <= 30; c++) begin
            cycle(6'h3E, 1'b1, 1'b1);
            if (pressed[0]) begin
                pulses++;
                if (first_pulse == 0) first_pulse = c;
            end
        end
        vectors++;
        if (first_pulse != D + 2 || pulses != 1) begin
            miscompares++;
            $display("FAIL press_pulse: at %0d x%0d, expected at %0d x1",
                     first_pulse, pulses, D + 2);
        end
        for (int c = 0; c < 23; c++) cycle(6'h3F, 1'b1, 1'b1);

        // Random levels with bounces, backpressure and rare resets
        lvl = '1;
        for (int k = 0; k < NK; k++) hold[k] = $urandom_range(1, 35);
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NK; k++) begin
                if (hold[k] == 0) begin
                    lvl[k] = ~lvl[k];
                    hold[k] = $urandom_range(1, 35);
                end
                hold[k]--;
            end
            cycle(lvl, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 599) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
